// File: rtl/renkon_window_mac.sv
// renkon_window_mac: fixed-point dot product of a FILTER x FILTER window against a
//   locally held kernel plus bias.
// Latency: LAT = 2 + ceil(log2(FILTER**2)) cycles (7 for FILTER=5), one window per cycle.
// Backpressure: none; every accepted window yields exactly one out_valid pulse.
//
// Ports:
//   clk, xrst              single rising-edge clock, asynchronous active-low reset
//   win_valid, win_data    window in; element FILTER*row+col at win_data[i*DWIDTH +: DWIDTH]
//   wreg_we/addr/data      kernel store write; addr 0..FILTER**2-1 = weight, FILTER**2 = bias
//   out_valid, out_data    rounded Q(FACT) result
//   mac_busy               high while any accepted window is still in the pipeline
//
// Build option: define RENKON_MAC_SAT_EN to clamp the result to the DWIDTH signed
// range; without it the result wraps to its low DWIDTH bits.

module renkon_window_mac #(
  parameter int DWIDTH = 16,
  parameter int FACT   = 8,
  parameter int FILTER = 5
) (
  input  logic                                 clk,
  input  logic                                 xrst,
  input  logic                                 win_valid,
  input  logic [DWIDTH*FILTER*FILTER-1:0]      win_data,
  input  logic                                 wreg_we,
  input  logic [$clog2(FILTER*FILTER+1)-1:0]   wreg_addr,
  input  logic signed [DWIDTH-1:0]             wreg_data,
  output logic                                 out_valid,
  output logic signed [DWIDTH-1:0]             out_data,
  output logic                                 mac_busy
);

  localparam int NW     = FILTER * FILTER;
  localparam int AW     = $clog2(NW + 1);
  localparam int LEVELS = $clog2(NW);
  localparam int LAT    = LEVELS + 2;
  localparam int PW     = 2 * DWIDTH;
  localparam int SW     = PW + LEVELS;
  localparam int OW     = SW + 2;

  // Half-LSB of the output format, added before the arithmetic shift (round half up).
  localparam logic [OW-1:0] RND = {{(OW-FACT){1'b0}}, 1'b1, {(FACT-1){1'b0}}};

  function automatic int level_cnt(input int lv);
    return (NW + (1 << lv) - 1) >> lv;
  endfunction

  // ---------------------------------------------------------------------------
  // Kernel store
  // ---------------------------------------------------------------------------
  logic signed [DWIDTH-1:0] weight [NW];
  logic signed [DWIDTH-1:0] bias;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int k = 0; k < NW; k++) weight[k] <= '0;
      bias <= '0;
    end else if (wreg_we) begin
      for (int k = 0; k < NW; k++) begin
        if (wreg_addr == AW'(k)) weight[k] <= wreg_data;
      end
      // Addresses above NW match nothing and are dropped.
      if (wreg_addr == AW'(NW)) bias <= wreg_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Level 0: registered products. Level lv>0: registered pairwise sums, one bit
  // wider than the level below; an odd leftover element is carried up unchanged.
  // Products read the weight registers before this edge's write lands, so a
  // coincident kernel write only affects later windows.
  // ---------------------------------------------------------------------------
  for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
    localparam int CNT = level_cnt(lv);
    localparam int W   = PW + lv;
    logic signed [W-1:0] node [CNT];

    if (lv == 0) begin : g_mul
      always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
          for (int k = 0; k < CNT; k++) node[k] <= '0;
        end else begin
          for (int k = 0; k < CNT; k++)
            node[k] <= $signed(win_data[k*DWIDTH +: DWIDTH]) * weight[k];
        end
      end
    end else begin : g_add
      localparam int PCNT = level_cnt(lv - 1);
      always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
          for (int k = 0; k < CNT; k++) node[k] <= '0;
        end else begin
          for (int k = 0; k < PCNT / 2; k++)
            node[k] <= {g_lvl[lv-1].node[2*k][W-2],   g_lvl[lv-1].node[2*k]}
                     + {g_lvl[lv-1].node[2*k+1][W-2], g_lvl[lv-1].node[2*k+1]};
          if (PCNT % 2 == 1)
            node[CNT-1] <= {g_lvl[lv-1].node[PCNT-1][W-2], g_lvl[lv-1].node[PCNT-1]};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: add bias aligned to the product scale, round, rescale, reduce.
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0]     sum_top;
  logic signed [OW-1:0]     s_full;
  logic signed [DWIDTH-1:0] r_out;
  logic                     unused_bits;

  assign sum_top = g_lvl[LEVELS].node[0];
  assign s_full  = {{(OW-SW){sum_top[SW-1]}}, sum_top}
                 + ({{(OW-DWIDTH){bias[DWIDTH-1]}}, bias} << FACT)
                 + RND;

`ifdef RENKON_MAC_SAT_EN
  localparam logic signed [OW-1:0] MAXV = {{(OW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [OW-1:0] MINV = {{(OW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
  logic signed [OW-1:0] r_full;

  assign r_full = s_full >>> FACT;

  always_comb begin
    r_out = r_full[DWIDTH-1:0];
    if (r_full > MAXV)      r_out = {1'b0, {(DWIDTH-1){1'b1}}};
    else if (r_full < MINV) r_out = {1'b1, {(DWIDTH-1){1'b0}}};
  end

  // Fraction bits are consumed by the rounding add, not by the result.
  assign unused_bits = ^s_full[FACT-1:0];
`else
  // Wrap-around: the result is simply the DWIDTH-bit field above the fraction.
  assign r_out       = s_full[FACT +: DWIDTH];
  assign unused_bits = ^{s_full[OW-1:FACT+DWIDTH], s_full[FACT-1:0]};
`endif

  // ---------------------------------------------------------------------------
  // Valid shift register runs alongside the data path; out_valid is its last tap.
  // ---------------------------------------------------------------------------
  logic [LAT-1:0] vld;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      vld      <= '0;
      out_data <= '0;
    end else begin
      vld      <= {vld[LAT-2:0], win_valid};
      out_data <= r_out;
    end
  end

  assign out_valid = vld[LAT-1];
  assign mac_busy  = |vld;

endmodule

// File: tb/tb_renkon_window_mac.sv
module tb_renkon_window_mac;

  logic               clk = 1'b0;
  logic               xrst;
  logic               win_valid = 1'b0;
  logic [399:0]       win_data = '0;
  logic               wreg_we = 1'b0;
  logic [4:0]         wreg_addr = '0;
  logic signed [15:0] wreg_data = '0;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               mac_busy;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] got[$];
  int                 got_cyc[$];
  int                 busy_cnt;

  logic signed [15:0] tw [25];
  logic signed [15:0] tb_bias;

  renkon_window_mac #(.DWIDTH(16), .FACT(8), .FILTER(5)) dut (
    .clk       (clk),
    .xrst      (xrst),
    .win_valid (win_valid),
    .win_data  (win_data),
    .wreg_we   (wreg_we),
    .wreg_addr (wreg_addr),
    .wreg_data (wreg_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .mac_busy  (mac_busy)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers (no checking inside) ----------------
  function automatic logic [399:0] fill(input logic signed [15:0] v);
    logic [399:0] r;
    for (int j = 0; j < 25; j++) r[j*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [399:0] one_hot(input int idx, input logic signed [15:0] v);
    logic [399:0] r;
    r = '0;
    r[idx*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [399:0] ramp(input int k);
    logic [399:0] r;
    for (int j = 0; j < 25; j++) r[j*16 +: 16] = 16'(((k * 37 + j * 101) % 4096) - 2048);
    return r;
  endfunction

  // Reference: exact integer dot product, bias scaled by 2^8, round half up, reduce.
  function automatic logic signed [15:0] model(input logic [399:0] w);
    longint acc;
    acc = 0;
    for (int j = 0; j < 25; j++)
      acc += longint'($signed(w[j*16 +: 16])) * longint'(tw[j]);
    acc += longint'(tb_bias) * 256;
    acc += 128;
    acc = acc >>> 8;
`ifdef RENKON_MAC_SAT_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return acc[15:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    win_valid = 1'b0;
    wreg_we   = 1'b0;
    xrst      = 1'b0;
    @(negedge clk);
    xrst = 1'b1;
  endtask

  task automatic write_reg(input int addr, input logic signed [15:0] val);
    wreg_we   = 1'b1;
    wreg_addr = 5'(addr);
    wreg_data = val;
    @(negedge clk);
    wreg_we   = 1'b0;
  endtask

  // Runs a fixed number of cycles, dropping win_valid/wreg_we after the first edge,
  // and records every out_valid pulse with its cycle index plus busy cycles.
  task automatic collect(input int cycles);
    got.delete();
    got_cyc.delete();
    busy_cnt = 0;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      win_valid = 1'b0;
      wreg_we   = 1'b0;
      if (out_valid === 1'b1) begin
        got.push_back(out_data);
        got_cyc.push_back(c);
      end
      if (mac_busy === 1'b1) busy_cnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    xrst = 1'b1;
    #2 xrst = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0d expected 0", out_valid); end
    total++; if (mac_busy !== 1'b0) begin bad++; $display("FAIL reset_mac_busy: got %0d expected 0", mac_busy); end
    total++; if (out_data !== 16'sd0) begin bad++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    xrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    for (int j = 0; j < 25; j++) write_reg(j, 16'sd256);
    win_valid = 1'b1;
    win_data  = fill(16'sd256);
    collect(12);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL basic_pulses: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got_cyc[0] !== 7) begin bad++; $display("FAIL basic_latency: got %0d expected 7", got_cyc[0]); end
      total++; if (got[0] !== 16'sd6400) begin bad++; $display("FAIL basic_data: got %0d expected 6400", got[0]); end
    end
    total++; if (busy_cnt !== 7) begin bad++; $display("FAIL basic_busy_cycles: got %0d expected 7", busy_cnt); end
  endtask

  task automatic test_rounding();
    do_reset();
    write_reg(12, 16'sd128);
    win_valid = 1'b1; win_data = one_hot(12, 16'sd3);
    collect(10);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL round_up_pulses: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== 16'sd2) begin bad++; $display("FAIL round_up_data: got %0d expected 2", got[0]); end
    end
    win_valid = 1'b1; win_data = one_hot(12, -16'sd1);
    collect(10);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL round_neg_pulses: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== 16'sd0) begin bad++; $display("FAIL round_neg_data: got %0d expected 0", got[0]); end
    end
    write_reg(25, 16'sd256);
    win_valid = 1'b1; win_data = one_hot(12, -16'sd1);
    collect(10);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL bias_pulses: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== 16'sd256) begin bad++; $display("FAIL bias_data: got %0d expected 256", got[0]); end
    end
    // Address beyond the bias register must not disturb anything.
    write_reg(30, 16'sd1000);
    win_valid = 1'b1; win_data = one_hot(12, 16'sd3);
    collect(10);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL bad_addr_pulses: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== 16'sd258) begin bad++; $display("FAIL bad_addr_data: got %0d expected 258", got[0]); end
    end
  endtask

  task automatic test_overflow();
    logic signed [15:0] exp_ovf;
`ifdef RENKON_MAC_SAT_EN
    exp_ovf = 16'sd32767;
`else
    exp_ovf = -16'sd6400;
`endif
    do_reset();
    for (int j = 0; j < 25; j++) write_reg(j, 16'sd32767);
    win_valid = 1'b1; win_data = fill(16'sd32767);
    collect(10);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL ovf_pulses: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== exp_ovf) begin bad++; $display("FAIL ovf_data: got %0d expected %0d", got[0], exp_ovf); end
    end
  endtask

  task automatic test_collision();
    do_reset();
    wreg_we = 1'b1; wreg_addr = 5'd0; wreg_data = 16'sd256;
    win_valid = 1'b1; win_data = one_hot(0, 16'sd256);
    @(negedge clk);
    wreg_we = 1'b0;
    collect(12);
    total++; if (got.size() !== 2) begin bad++; $display("FAIL collide_pulses: got %0d expected 2", got.size()); end
    if (got.size() > 1) begin
      total++; if (got[0] !== 16'sd0) begin bad++; $display("FAIL collide_a: got %0d expected 0", got[0]); end
      total++; if (got[1] !== 16'sd256) begin bad++; $display("FAIL collide_b: got %0d expected 256", got[1]); end
      total++; if (got_cyc[0] !== 6 || got_cyc[1] !== 7) begin
        bad++; $display("FAIL collide_timing: got %0d,%0d expected 6,7", got_cyc[0], got_cyc[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 25; j++) write_reg(j, 16'sd256);
    win_valid = 1'b1; win_data = fill(16'sd256);
    repeat (3) @(negedge clk);
    win_valid = 1'b0;
    @(negedge clk);
    total++; if (mac_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %0d expected 1", mac_busy); end
    xrst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid_async: got %0d expected 0", out_valid); end
    total++; if (mac_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_async: got %0d expected 0", mac_busy); end
    @(negedge clk);
    xrst = 1'b1;
    collect(12);
    total++; if (got.size() !== 0) begin bad++; $display("FAIL mid_no_output: got %0d expected 0", got.size()); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL mid_no_busy: got %0d expected 0", busy_cnt); end
    win_valid = 1'b1; win_data = fill(16'sd256);
    collect(12);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL mid_new_pulses: got %0d expected 1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== 16'sd0) begin bad++; $display("FAIL mid_cleared_kernel: got %0d expected 0", got[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] exp_q[$];
    int gaps;
    do_reset();
    for (int j = 0; j < 25; j++) begin
      tw[j] = 16'(j * 300 - 3600);
      write_reg(j, tw[j]);
    end
    tb_bias = -16'sd1234;
    write_reg(25, tb_bias);
    got.delete();
    got_cyc.delete();
    for (int c = 0; c < 1024 + 16; c++) begin
      if (c < 1024) begin
        win_valid = 1'b1;
        win_data  = ramp(c);
        exp_q.push_back(model(ramp(c)));
      end else begin
        win_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got.push_back(out_data);
        got_cyc.push_back(c + 1);
      end
    end
    total++; if (got.size() !== 1024) begin bad++; $display("FAIL stream_pulses: got %0d expected 1024", got.size()); end
    if (got.size() > 0) begin
      total++; if (got_cyc[0] !== 7) begin bad++; $display("FAIL stream_first_latency: got %0d expected 7", got_cyc[0]); end
    end
    gaps = 0;
    for (int i = 0; i < got.size(); i++) if (got_cyc[i] !== 7 + i) gaps++;
    total++; if (gaps !== 0) begin bad++; $display("FAIL stream_gaps: got %0d misplaced pulses expected 0", gaps); end
    for (int i = 0; i < got.size() && i < 1024; i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++; $display("FAIL stream_data[%0d]: got %0d expected %0d", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 25; j++) tw[j] = '0;
    tb_bias = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/renkon_window_mac.md
# renkon_window_mac

Consumes the FILTER×FILTER windows produced by the padded line buffer and computes a fixed-point dot product against a locally held kernel plus bias. It sits directly downstream of the line buffer in the renkon convolution path, one window per cycle at full throughput. Results go to the accumulation/activation stage that follows.

## Interface
- DWIDTH, 16, data/weight/bias width, signed two's complement
- FACT, 8, fractional bits of the Q format shared by data, weights, bias and output
- FILTER, 5, kernel edge; window has FILTER**2 elements
- clk  in  1  single clock, rising edge
- xrst  in  1  reset; asynchronous and active-low
- win_valid  in  1  window element bus valid this cycle (driven by line-buffer valid)
- win_data  in  DWIDTH×FILTER**2  signed window, element FILTER*row+col
- wreg_we  in  1  kernel/bias register write strobe
- wreg_addr  in  $clog2(FILTER**2+1)  0..FILTER**2-1 select a weight, FILTER**2 selects bias
- wreg_data  in  DWIDTH  signed write value
- out_valid  out  1  out_data valid
- out_data  out  DWIDTH  signed result
- mac_busy  out  1  high while any valid window is in flight

## Operation
- Kernel store: FILTER**2 weight registers plus one bias register, written by wreg_we at the rising edge; wreg_addr > FILTER**2 ignored.
- Stage M (1 cycle): FILTER**2 signed products, each 2*DWIDTH bits, registered. Products use weight values held before the current edge, so a write coincident with win_valid does not affect that window; the next window sees the new value.
- Stage T (ceil(log2(FILTER**2)) cycles): registered binary adder tree; each level widens by 1 bit; odd element passes through with a register. No truncation inside the tree.
- Stage O (1 cycle): s = sum + (bias <<< FACT) + (1 <<< (FACT-1)); r = s >>> FACT (arithmetic, round-half-up); r reduced to DWIDTH per Configuration; registered to out_data.
- Valid pipeline: win_valid shifted alongside data; out_valid is its final tap. Data registers advance every cycle regardless of valid; out_data holds its last value only when out_valid is low if the implementation gates it. Receivers must sample out_data only with out_valid.
- mac_busy = OR of all valid pipeline taps, including out_valid.
- No backpressure: every accepted window produces exactly one result LAT cycles later; back-to-back windows produce back-to-back results.

## Timing
- LAT = 2 + ceil(log2(FILTER**2)); FILTER=5 → 7, FILTER=3 → 6. Window sampled at edge n appears at out_data/out_valid after edge n+LAT-1... defined as: out_valid high in cycle n+LAT when win_valid high in cycle n.
- Reset (xrst low, asynchronous): out_valid=0, mac_busy=0, out_data=0, all weights=0, bias=0, all pipeline registers=0. Reset mid-stream drops every in-flight window; no result emerges after release.
- First win_valid may be sampled on the first edge after xrst deasserts.
- Simultaneous wreg_we to the same address twice in consecutive cycles: last write wins.

## Configuration
- RENKON_MAC_SAT_EN defined: r clamped to [-(2**(DWIDTH-1)), 2**(DWIDTH-1)-1].
- Undefined: r truncated to its low DWIDTH bits (wrap-around), no clamp logic generated.

## Test plan
- All weights 256, bias 0, window all 256, single win_valid → exactly one out_valid pulse 7 cycles later, out_data=6400; mac_busy high for the 7 intervening cycles.
- Rounding: only weight[12]=128, window[12]=3 → out_data=2; window[12]=-1 → out_data=0; then bias=256 with same window → out_data=256 higher than without bias.
- Overflow: all weights and window 32767 → with RENKON_MAC_SAT_EN out_data=32767; without it out_data=-6400.
- Streaming: 1024 consecutive win_valid cycles with ramp windows → 1024 consecutive out_valid cycles matching a software model, no gaps, no extra pulses.
- Write/window collision: weight[0] 0→256 written in the same cycle as window A (window[0]=256) then window B identical next cycle → A result 0, B result 256.
- Reset mid-operation: xrst low for 1 cycle while 3 windows in flight → out_valid and mac_busy low immediately, no out_valid afterward until new input, weights read back as zero effect (result 0 + rounding → 0).
